// File: rtl/mul_accumulator.sv
// mul_accumulator: buffers multiplier products in a small FIFO and sums a
// programmed number of them into a wide accumulator (dot-product job).
// Ports: clk, rst_n (async active-low); in_val/in_res/in_overflow product
// input; in_stall early backpressure to the multiplier; start/len job
// control; out_val/out_rdy/out_sum/out_ovf result; drop_err sticky drop flag.
// Option: define MUL_ACC_SATURATE_EN to clamp the accumulator on carry-out
// instead of wrapping.
module mul_accumulator #(
    parameter int PROD_WIDTH = 64,
    parameter int ACC_WIDTH  = 80,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_val,
    input  logic [PROD_WIDTH-1:0] in_res,
    input  logic                  in_overflow,
    output logic                  in_stall,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  len,
    output logic                  out_val,
    input  logic                  out_rdy,
    output logic [ACC_WIDTH-1:0]  out_sum,
    output logic                  out_ovf,
    output logic                  drop_err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int OW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state;
    logic [ACC_WIDTH-1:0]   acc;
    logic [CNT_WIDTH-1:0]   remaining;

    logic [PROD_WIDTH-1:0]  mem_res [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  mem_ovf;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [OW-1:0]          occ;

    logic                   full;
    logic                   pop;
    logic                   push;
    logic [ACC_WIDTH:0]     sum_ext;
    logic                   carry;
    logic [ACC_WIDTH-1:0]   acc_next;

    assign full = (occ == OW'(FIFO_DEPTH));
    assign pop  = (state == ACCUM) && (occ != '0);
    // A full FIFO still accepts a product when the same cycle frees a slot.
    assign push = in_val && (!full || pop);

    // Two free slots cover the products already inside the multiplier.
    assign in_stall = (OW'(FIFO_DEPTH) - occ) <= OW'(2);

    assign sum_ext = {1'b0, acc} + (ACC_WIDTH + 1)'(mem_res[rd_ptr]);
    assign carry   = sum_ext[ACC_WIDTH];

`ifdef MUL_ACC_SATURATE_EN
    // Once clamped, every further add carries again, so it stays clamped.
    assign acc_next = carry ? {ACC_WIDTH{1'b1}} : sum_ext[ACC_WIDTH-1:0];
`else
    assign acc_next = sum_ext[ACC_WIDTH-1:0];
`endif

    assign out_sum = acc;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_res[wr_ptr] <= in_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_ovf  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            drop_err <= 1'b0;
        end else begin
            if (push) begin
                mem_ovf[wr_ptr] <= in_overflow;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                occ <= occ + OW'(1);
            end else if (pop && !push) begin
                occ <= occ - OW'(1);
            end
            if (in_val && !push) begin
                drop_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            remaining <= '0;
            out_val   <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc     <= '0;
                        out_ovf <= 1'b0;
                        if (len != '0) begin
                            remaining <= len;
                            state     <= ACCUM;
                        end else begin
                            state   <= DONE;
                            out_val <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (pop) begin
                        acc       <= acc_next;
                        out_ovf   <= out_ovf | carry | mem_ovf[rd_ptr];
                        remaining <= remaining - CNT_WIDTH'(1);
                        if (remaining == CNT_WIDTH'(1)) begin
                            state   <= DONE;
                            out_val <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_rdy) begin
                        state   <= IDLE;
                        out_val <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    out_val <= 1'b0;
                end
            endcase
        end
    end

endmodule
